// File: rtl/ccu_snoop_ctrl_pkg.sv
// Shared constants and types for the CCU snoop controller.
package ccu_snoop_ctrl_pkg;

  // CRRESP bit positions within each port's 5-bit response field.
  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;
  localparam int unsigned CrRespWidth    = 5;

  // AC snoop codes for the supported request classes.
  localparam logic [3:0] SnpReadOnce    = 4'b0000;
  localparam logic [3:0] SnpReadShared  = 4'b0001;
  localparam logic [3:0] SnpCleanUnique = 4'b1001;

  typedef enum logic [2:0] {
    StIdle,
    StSnoop,
    StSnoopData,
    StMemReq,
    StMemData,
    StResp
  } ccu_state_e;

endpackage

// File: rtl/ccu_snoop_ctrl_lzc.sv
// Trailing-zero counter: returns the index of the lowest set bit (0 when the input is empty).
module ccu_snoop_ctrl_lzc #(
  parameter int unsigned Width = 4,
  parameter int unsigned CntW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o
);

  // Scan from the top so the lowest set bit is the last one to write cnt_o.
  always_comb begin
    cnt_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CntW'(i);
    end
  end

endmodule

// File: rtl/ccu_snoop_ctrl.sv
// Coherency-control FSM: broadcasts one snoop, merges CR responses and sources the line
// from a snooped master's CD channel or from memory before answering the initiator.
module ccu_snoop_ctrl
  import ccu_snoop_ctrl_pkg::*;
#(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned IdxW       = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [AddrWidth-1:0]            req_addr_i,
  input  logic [3:0]                      req_snoop_i,
  input  logic [2:0]                      req_prot_i,
  input  logic [IdxW-1:0]                 req_src_i,
  output logic [NoMstPorts-1:0]           ac_valid_o,
  input  logic [NoMstPorts-1:0]           ac_ready_i,
  output logic [AddrWidth-1:0]            ac_addr_o,
  output logic [3:0]                      ac_snoop_o,
  output logic [2:0]                      ac_prot_o,
  input  logic [NoMstPorts-1:0]           cr_valid_i,
  output logic [NoMstPorts-1:0]           cr_ready_o,
  input  logic [5*NoMstPorts-1:0]         cr_resp_i,
  input  logic [NoMstPorts-1:0]           cd_valid_i,
  output logic [NoMstPorts-1:0]           cd_ready_o,
  input  logic [DataWidth*NoMstPorts-1:0] cd_data_i,
  input  logic [NoMstPorts-1:0]           cd_last_i,
  output logic                            mem_ar_valid_o,
  input  logic                            mem_ar_ready_i,
  output logic [AddrWidth-1:0]            mem_ar_addr_o,
  input  logic                            mem_r_valid_i,
  output logic                            mem_r_ready_o,
  input  logic [DataWidth-1:0]            mem_r_data_i,
  input  logic                            mem_r_last_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [DataWidth-1:0]            rsp_data_o,
  output logic                            rsp_last_o,
  output logic                            rsp_shared_o,
  output logic                            rsp_dirty_o,
  output logic                            rsp_err_o
);

  ccu_state_e            state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [3:0]            snoop_q, snoop_d;
  logic [2:0]            prot_q, prot_d;
  logic                  read_q, read_d;
  logic [NoMstPorts-1:0] ac_pend_q, ac_pend_d;
  logic [NoMstPorts-1:0] cr_pend_q, cr_pend_d;
  logic [NoMstPorts-1:0] dt_mask_q, dt_mask_d;
  logic [NoMstPorts-1:0] dirty_q, dirty_d;
  logic                  shared_q, shared_d;
  logic                  err_q, err_d;
  logic [IdxW-1:0]       sel_q, sel_d;

  logic [NoMstPorts-1:0] tgt_mask;
  logic [NoMstPorts-1:0] cr_hs;
  logic [NoMstPorts-1:0] cr_dt;
  logic [NoMstPorts-1:0] cd_hs;
  logic [NoMstPorts-1:0] dt_snoop_next;
  logic [IdxW-1:0]       dt_low_idx;

  // Every port except the initiator is snooped.
  assign tgt_mask = ~(NoMstPorts'(1) << req_src_i);

  // A port's CR may be taken as soon as its own AC has gone out.
  assign cr_ready_o = (state_q == StSnoop) ? (cr_pend_q & ~ac_pend_q) : '0;
  assign cr_hs      = cr_valid_i & cr_ready_o;

  // Extract per-port DataTransfer bits.
  always_comb begin
    cr_dt = '0;
    for (int p = 0; p < NoMstPorts; p++) begin
      cr_dt[p] = cr_resp_i[p*CrRespWidth + CrDataTransfer];
    end
  end

  // Data-source candidates including this cycle's CR handshakes, so sel is latched on entry.
  assign dt_snoop_next = dt_mask_q | (cr_hs & cr_dt);

  ccu_snoop_ctrl_lzc #(
    .Width (NoMstPorts),
    .CntW  (IdxW)
  ) u_sel_lzc (
    .in_i  (dt_snoop_next),
    .cnt_o (dt_low_idx)
  );

  assign ac_addr_o     = addr_q;
  assign ac_snoop_o    = snoop_q;
  assign ac_prot_o     = prot_q;
  assign mem_ar_addr_o = addr_q;
  assign rsp_shared_o  = shared_q;
  assign rsp_err_o     = err_q;

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    snoop_d   = snoop_q;
    prot_d    = prot_q;
    read_d    = read_q;
    ac_pend_d = ac_pend_q;
    cr_pend_d = cr_pend_q;
    dt_mask_d = dt_mask_q;
    dirty_d   = dirty_q;
    shared_d  = shared_q;
    err_d     = err_q;
    sel_d     = sel_q;

    req_ready_o    = 1'b0;
    ac_valid_o     = '0;
    cd_ready_o     = '0;
    cd_hs          = '0;
    mem_ar_valid_o = 1'b0;
    mem_r_ready_o  = 1'b0;
    rsp_valid_o    = 1'b0;
    rsp_data_o     = '0;
    rsp_last_o     = 1'b0;
    rsp_dirty_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Held low while reset is asserted so no valid/ready is visible during reset.
        req_ready_o = rst_ni;
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          snoop_d   = req_snoop_i;
          prot_d    = req_prot_i;
          read_d    = ~req_snoop_i[3];
          ac_pend_d = tgt_mask;
          cr_pend_d = tgt_mask;
          dt_mask_d = '0;
          dirty_d   = '0;
          shared_d  = 1'b0;
          err_d     = 1'b0;
          if (tgt_mask == '0) begin
            state_d = req_snoop_i[3] ? StResp : StMemReq;
          end else begin
            state_d = StSnoop;
          end
        end
      end

      StSnoop: begin
        ac_valid_o = ac_pend_q;
        ac_pend_d  = ac_pend_q & ~ac_ready_i;
        cr_pend_d  = cr_pend_q & ~cr_hs;
        dt_mask_d  = dt_snoop_next;
        for (int p = 0; p < NoMstPorts; p++) begin
          if (cr_hs[p]) begin
            shared_d   = shared_d | cr_resp_i[p*CrRespWidth + CrIsShared];
            err_d      = err_d | cr_resp_i[p*CrRespWidth + CrError];
            dirty_d[p] = cr_resp_i[p*CrRespWidth + CrPassDirty];
          end
        end
        if (ac_pend_d == '0 && cr_pend_d == '0) begin
          if (dt_snoop_next != '0) begin
            state_d = StSnoopData;
            sel_d   = dt_low_idx;
          end else begin
            state_d = read_q ? StMemReq : StResp;
          end
        end
      end

      StSnoopData: begin
        // Every data-transferring port is drained; only sel is forwarded (read class).
        cd_ready_o = dt_mask_q;
        if (read_q && dt_mask_q[sel_q]) begin
          cd_ready_o[sel_q] = rsp_ready_i;
          rsp_valid_o       = cd_valid_i[sel_q];
          rsp_data_o        = cd_data_i[sel_q*DataWidth +: DataWidth];
          rsp_last_o        = cd_last_i[sel_q];
          rsp_dirty_o       = dirty_q[sel_q];
        end
        cd_hs     = cd_valid_i & cd_ready_o;
        dt_mask_d = dt_mask_q & ~(cd_hs & cd_last_i);
        if (dt_mask_d == '0) begin
          state_d = read_q ? StIdle : StResp;
        end
      end

      StMemReq: begin
        mem_ar_valid_o = 1'b1;
        if (mem_ar_ready_i) state_d = StMemData;
      end

      StMemData: begin
        mem_r_ready_o = rsp_ready_i;
        rsp_valid_o   = mem_r_valid_i;
        rsp_data_o    = mem_r_data_i;
        rsp_last_o    = mem_r_last_i;
        if (mem_r_valid_i && rsp_ready_i && mem_r_last_i) state_d = StIdle;
      end

      StResp: begin
        rsp_valid_o = 1'b1;
        rsp_last_o  = 1'b1;
        if (rsp_ready_i) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and transaction context registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
      read_q    <= 1'b0;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      dt_mask_q <= '0;
      dirty_q   <= '0;
      shared_q  <= 1'b0;
      err_q     <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      prot_q    <= prot_d;
      read_q    <= read_d;
      ac_pend_q <= ac_pend_d;
      cr_pend_q <= cr_pend_d;
      dt_mask_q <= dt_mask_d;
      dirty_q   <= dirty_d;
      shared_q  <= shared_d;
      err_q     <= err_d;
      sel_q     <= sel_d;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_ctrl.sv
// Randomised bench for ccu_snoop_ctrl with a transaction-level reference model.
module tb_ccu_snoop_ctrl;
  import ccu_snoop_ctrl_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [AW-1:0]   req_addr_i = '0;
  logic [3:0]      req_snoop_i = '0;
  logic [2:0]      req_prot_i = '0;
  logic [IW-1:0]   req_src_i = '0;
  logic [N-1:0]    ac_valid_o;
  logic [N-1:0]    ac_ready_i = '0;
  logic [AW-1:0]   ac_addr_o;
  logic [3:0]      ac_snoop_o;
  logic [2:0]      ac_prot_o;
  logic [N-1:0]    cr_valid_i = '0;
  logic [N-1:0]    cr_ready_o;
  logic [5*N-1:0]  cr_resp_i = '0;
  logic [N-1:0]    cd_valid_i = '0;
  logic [N-1:0]    cd_ready_o;
  logic [DW*N-1:0] cd_data_i = '0;
  logic [N-1:0]    cd_last_i = '0;
  logic            mem_ar_valid_o;
  logic            mem_ar_ready_i = 1'b0;
  logic [AW-1:0]   mem_ar_addr_o;
  logic            mem_r_valid_i = 1'b0;
  logic            mem_r_ready_o;
  logic [DW-1:0]   mem_r_data_i = '0;
  logic            mem_r_last_i = 1'b0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic [DW-1:0]   rsp_data_o;
  logic            rsp_last_o;
  logic            rsp_shared_o;
  logic            rsp_dirty_o;
  logic            rsp_err_o;

  ccu_snoop_ctrl #(
    .NoMstPorts (N),
    .AddrWidth  (AW),
    .DataWidth  (DW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_snoop_i    (req_snoop_i),
    .req_prot_i     (req_prot_i),
    .req_src_i      (req_src_i),
    .ac_valid_o     (ac_valid_o),
    .ac_ready_i     (ac_ready_i),
    .ac_addr_o      (ac_addr_o),
    .ac_snoop_o     (ac_snoop_o),
    .ac_prot_o      (ac_prot_o),
    .cr_valid_i     (cr_valid_i),
    .cr_ready_o     (cr_ready_o),
    .cr_resp_i      (cr_resp_i),
    .cd_valid_i     (cd_valid_i),
    .cd_ready_o     (cd_ready_o),
    .cd_data_i      (cd_data_i),
    .cd_last_i      (cd_last_i),
    .mem_ar_valid_o (mem_ar_valid_o),
    .mem_ar_ready_i (mem_ar_ready_i),
    .mem_ar_addr_o  (mem_ar_addr_o),
    .mem_r_valid_i  (mem_r_valid_i),
    .mem_r_ready_o  (mem_r_ready_o),
    .mem_r_data_i   (mem_r_data_i),
    .mem_r_last_i   (mem_r_last_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_last_o     (rsp_last_o),
    .rsp_shared_o   (rsp_shared_o),
    .rsp_dirty_o    (rsp_dirty_o),
    .rsp_err_o      (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-transaction configuration.
  int          txn_id = 0;
  logic [63:0] cfg_addr;
  logic [3:0]  cfg_snoop;
  logic [2:0]  cfg_prot;
  int          cfg_src;
  logic [4:0]  cfg_resp [N];
  int          cfg_cd_beats [N];
  int          cfg_ac_delay [N];
  int          cfg_mem_beats;
  bit          cfg_toggle_rdy;
  int          cfg_abort_after;

  function automatic logic [63:0] cd_word(input int t, input int p, input int b);
    return {16'(t), 16'(p), 16'(b), 16'hCD00};
  endfunction

  function automatic logic [63:0] mem_word(input int t, input int b);
    return {16'(t), 16'hFFFF, 16'(b), 16'hAA00};
  endfunction

  task automatic cfg_default();
    txn_id++;
    cfg_addr        = {$urandom, $urandom} & ~64'h3f;
    cfg_snoop       = SnpReadShared;
    cfg_prot        = 3'($urandom_range(0, 7));
    cfg_src         = 0;
    cfg_mem_beats   = 4;
    cfg_toggle_rdy  = 1'b0;
    cfg_abort_after = 0;
    for (int p = 0; p < N; p++) begin
      cfg_resp[p]     = 5'b0;
      cfg_cd_beats[p] = 4;
      cfg_ac_delay[p] = 0;
    end
  endtask

  task automatic clear_inputs();
    req_valid_i    = 1'b0;
    ac_ready_i     = '0;
    cr_valid_i     = '0;
    cd_valid_i     = '0;
    cd_last_i      = '0;
    mem_ar_ready_i = 1'b0;
    mem_r_valid_i  = 1'b0;
    mem_r_last_i   = 1'b0;
    rsp_ready_i    = 1'b0;
  endtask

  task automatic run_txn();
    logic [N-1:0]  tgt, dt, ac_seen, ac_done, cr_done, cr_hold, cd_hold, cr_hs, cd_hs;
    logic [63:0]   exp_data[$];
    logic          exp_last[$];
    logic          rd, exp_shared, exp_err, exp_dirty, exp_mem, all_cr_prev;
    logic          ar_seen, mem_hold, prev_pend, accepted, done, left;
    logic [63:0]   prev_data;
    int            sel, cyc, ac_cnt, beats_seen, mem_rem, mem_idx;
    int            cd_rem[N];
    int            cd_idx[N];

    // Reference model: expected snoop targets and response beats.
    rd = (cfg_snoop[3] == 1'b0);
    tgt = '0;
    dt = '0;
    exp_shared = 1'b0;
    exp_err = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (p != cfg_src) begin
        tgt[p] = 1'b1;
        dt[p] = cfg_resp[p][0];
        exp_shared |= cfg_resp[p][3];
        exp_err |= cfg_resp[p][1];
      end
    end
    sel = -1;
    for (int p = N - 1; p >= 0; p--) if (dt[p]) sel = p;
    exp_dirty = 1'b0;
    exp_mem = 1'b0;
    if (!rd) begin
      exp_data.push_back(64'h0);
      exp_last.push_back(1'b1);
    end else if (sel >= 0) begin
      exp_dirty = cfg_resp[sel][2];
      for (int b = 0; b < cfg_cd_beats[sel]; b++) begin
        exp_data.push_back(cd_word(txn_id, sel, b));
        exp_last.push_back(b == cfg_cd_beats[sel] - 1);
      end
    end else begin
      exp_mem = 1'b1;
      for (int b = 0; b < cfg_mem_beats; b++) begin
        exp_data.push_back(mem_word(txn_id, b));
        exp_last.push_back(b == cfg_mem_beats - 1);
      end
    end

    ac_seen = '0; ac_done = '0; cr_done = '0; cr_hold = '0; cd_hold = '0;
    for (int p = 0; p < N; p++) begin
      cd_rem[p] = dt[p] ? cfg_cd_beats[p] : 0;
      cd_idx[p] = 0;
    end
    ar_seen = 1'b0; mem_hold = 1'b0; mem_rem = 0; mem_idx = 0;
    prev_pend = 1'b0; prev_data = '0; accepted = 1'b0; done = 1'b0;
    cyc = 0; ac_cnt = 0; beats_seen = 0;

    while (!done && cyc < 400) begin
      @(negedge clk_i);
      // Drive responders for the coming edge.
      req_valid_i = !accepted;
      req_addr_i  = cfg_addr;
      req_snoop_i = cfg_snoop;
      req_prot_i  = cfg_prot;
      req_src_i   = IW'(cfg_src);
      for (int p = 0; p < N; p++) begin
        ac_ready_i[p] = accepted && (ac_cnt >= cfg_ac_delay[p]);
        cr_valid_i[p] = ac_done[p] && !cr_done[p] && (cr_hold[p] || ($urandom_range(0, 2) != 0));
        cr_resp_i[p*5 +: 5] = cfg_resp[p];
        cd_valid_i[p] = cr_done[p] && (cd_rem[p] > 0) && (cd_hold[p] || ($urandom_range(0, 3) != 0));
        cd_data_i[p*DW +: DW] = cd_word(txn_id, p, cd_idx[p]);
        cd_last_i[p] = (cd_rem[p] == 1);
      end
      mem_ar_ready_i = 1'($urandom_range(0, 1));
      mem_r_valid_i  = ar_seen && (mem_rem > 0) && (mem_hold || ($urandom_range(0, 3) != 0));
      mem_r_data_i   = mem_word(txn_id, mem_idx);
      mem_r_last_i   = (mem_rem == 1);
      rsp_ready_i    = cfg_toggle_rdy ? 1'(cyc % 2) : ($urandom_range(0, 3) != 0);
      #1;
      // Observe what the coming edge will see.
      if (!accepted) begin
        if (req_ready_o) accepted = 1'b1;
      end else begin
        if (req_ready_o) done = 1'b1;
        if (ac_cnt == 0) check_eq("ac_first", ac_valid_o, tgt);
        if (ac_valid_o != '0) begin
          check_eq("ac_addr", ac_addr_o, cfg_addr);
          check_eq("ac_snoop", ac_snoop_o, cfg_snoop);
          check_eq("ac_prot", ac_prot_o, cfg_prot);
          check_eq("ac_once", ac_valid_o & ac_done, 0);
        end
        ac_seen |= ac_valid_o;
        ac_done |= ac_valid_o & ac_ready_i;
        all_cr_prev = (cr_done == tgt);
        cr_hs = cr_valid_i & cr_ready_o;
        cr_done |= cr_hs;
        cr_hold = cr_valid_i & ~cr_hs;
        if (rd && sel >= 0 && all_cr_prev && cd_rem[sel] > 0 && cd_valid_i[sel])
          check_eq("cd_rdy_mirror", cd_ready_o[sel], rsp_ready_i);
        cd_hs = cd_valid_i & cd_ready_o;
        for (int p = 0; p < N; p++) begin
          if (cd_hs[p]) begin
            cd_rem[p]--;
            cd_idx[p]++;
          end
        end
        cd_hold = cd_valid_i & ~cd_hs;
        if (mem_ar_valid_o) begin
          check_eq("ar_addr", mem_ar_addr_o, cfg_addr);
          check_eq("ar_once", ar_seen, 0);
          if (mem_ar_ready_i) begin
            ar_seen = 1'b1;
            mem_rem = cfg_mem_beats;
          end
        end
        if (mem_r_valid_i && mem_r_ready_o) begin
          mem_rem--;
          mem_idx++;
        end
        mem_hold = mem_r_valid_i && !mem_r_ready_o;
        if (prev_pend) begin
          check_eq("rsp_hold", rsp_valid_o, 1);
          check_eq("rsp_stable", rsp_data_o, prev_data);
        end
        if (rsp_valid_o && rsp_ready_i) begin
          if (exp_data.size() == 0) begin
            check_eq("rsp_extra", rsp_valid_o, 0);
          end else begin
            check_eq("rsp_data", rsp_data_o, exp_data.pop_front());
            check_eq("rsp_last", rsp_last_o, exp_last.pop_front());
            check_eq("rsp_shared", rsp_shared_o, exp_shared);
            check_eq("rsp_dirty", rsp_dirty_o, exp_dirty);
            check_eq("rsp_err", rsp_err_o, exp_err);
          end
          beats_seen++;
        end
        prev_pend = rsp_valid_o && !rsp_ready_i;
        prev_data = rsp_data_o;
        ac_cnt++;
        if (cfg_abort_after > 0 && beats_seen >= cfg_abort_after) begin
          rst_ni = 1'b0;
          #1;
          check_eq("rst_ac_valid", ac_valid_o, 0);
          check_eq("rst_cr_ready", cr_ready_o, 0);
          check_eq("rst_cd_ready", cd_ready_o, 0);
          check_eq("rst_mem_ar", mem_ar_valid_o, 0);
          check_eq("rst_mem_r_rdy", mem_r_ready_o, 0);
          check_eq("rst_rsp_valid", rsp_valid_o, 0);
          check_eq("rst_req_ready", req_ready_o, 0);
          @(negedge clk_i);
          clear_inputs();
          @(negedge clk_i);
          rst_ni = 1'b1;
          #1;
          check_eq("rst_rel_ready", req_ready_o, 1);
          check_eq("rst_rel_rsp", rsp_valid_o, 0);
          return;
        end
      end
      cyc++;
    end

    check_eq("txn_done", done, 1);
    check_eq("ac_targets", ac_seen, tgt);
    check_eq("mem_ar_used", ar_seen, exp_mem);
    check_eq("beats_left", exp_data.size(), 0);
    left = 1'b0;
    for (int p = 0; p < N; p++) if (cd_rem[p] != 0) left = 1'b1;
    check_eq("cd_drained", left, 0);
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    #12;
    check_eq("reset_req_ready", req_ready_o, 0);
    check_eq("reset_ac_valid", ac_valid_o, 0);
    check_eq("reset_rsp_valid", rsp_valid_o, 0);
    check_eq("reset_mem_ar", mem_ar_valid_o, 0);
    check_eq("reset_ac_addr", ac_addr_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_eq("idle_req_ready", req_ready_o, 1);

    // All miss: memory sourced.
    cfg_default();
    run_txn();
    // Port 2 shared dirty data transfer.
    cfg_default();
    cfg_resp[2] = 5'b01101;
    run_txn();
    // Ports 1 and 3 both transfer data; port 3 is drained.
    cfg_default();
    cfg_snoop = SnpReadOnce;
    cfg_resp[1] = 5'b00001;
    cfg_resp[3] = 5'b00001;
    cfg_cd_beats[3] = 3;
    run_txn();
    // CleanUnique with slow port 1 and error on port 3.
    cfg_default();
    cfg_snoop = SnpCleanUnique;
    cfg_ac_delay[1] = 5;
    cfg_resp[3] = 5'b00010;
    run_txn();
    // Toggling initiator ready during CD forwarding.
    cfg_default();
    cfg_resp[1] = 5'b00001;
    cfg_toggle_rdy = 1'b1;
    run_txn();
    // Reset in the middle of CD forwarding, then a clean transaction.
    cfg_default();
    cfg_resp[2] = 5'b00101;
    cfg_abort_after = 2;
    run_txn();
    cfg_default();
    cfg_resp[3] = 5'b01001;
    run_txn();

    for (int t = 0; t < 40; t++) begin
      cfg_default();
      cfg_src = $urandom_range(0, N - 1);
      case ($urandom_range(0, 2))
        0:       cfg_snoop = SnpReadOnce;
        1:       cfg_snoop = SnpReadShared;
        default: cfg_snoop = SnpCleanUnique;
      endcase
      cfg_mem_beats = $urandom_range(1, 4);
      for (int p = 0; p < N; p++) begin
        cfg_resp[p]     = 5'($urandom_range(0, 31));
        cfg_cd_beats[p] = $urandom_range(1, 4);
        cfg_ac_delay[p] = $urandom_range(0, 3);
      end
      run_txn();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccu_snoop_ctrl.md
Name: ccu_snoop_ctrl

Overview:
Parametrised coherency-control FSM for the CCU. It accepts one arbitrated coherent request (ReadOnce, ReadShared or CleanUnique class) and broadcasts the snoop on the AC channel to every snooping master except the initiator. It collects and merges all CR responses, sources line data from a snooped master's CD channel or falls back to a memory read, and returns the merged response and data to the initiator. It sits between the CCU request arbiter and the per-master snoop ports and memory-side AXI master.

Parameters:
NoMstPorts, 4, number of snooping master ports (>=1)
AddrWidth, 64, address width
DataWidth, 64, CD/R data width
IdxW, $clog2(NoMstPorts) (min 1), derived, do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  coherent request valid
req_ready_o  out  1  request accepted
req_addr_i  in  AddrWidth  line address
req_snoop_i  in  4  AC snoop code to broadcast
req_prot_i  in  3  protection bits
req_src_i  in  IdxW  initiator port index (excluded from snoop)
ac_valid_o  out  NoMstPorts  per-port snoop valid
ac_ready_i  in  NoMstPorts  per-port snoop ready
ac_addr_o  out  AddrWidth  snoop address (shared)
ac_snoop_o  out  4  snoop code (shared)
ac_prot_o  out  3  snoop prot (shared)
cr_valid_i  in  NoMstPorts  snoop response valid
cr_ready_o  out  NoMstPorts  snoop response ready
cr_resp_i  in  5*NoMstPorts  CRRESP per port: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique
cd_valid_i  in  NoMstPorts  snoop data valid
cd_ready_o  out  NoMstPorts  snoop data ready
cd_data_i  in  DataWidth*NoMstPorts  snoop data
cd_last_i  in  NoMstPorts  last snoop beat
mem_ar_valid_o  out  1  memory read request
mem_ar_ready_i  in  1  memory read accepted
mem_ar_addr_o  out  AddrWidth  memory read address
mem_r_valid_i  in  1  memory read data valid
mem_r_ready_o  out  1  memory read data ready
mem_r_data_i  in  DataWidth  memory read data
mem_r_last_i  in  1  last memory beat
rsp_valid_o  out  1  response beat to initiator
rsp_ready_i  in  1  initiator accepts beat
rsp_data_o  out  DataWidth  response data
rsp_last_o  out  1  last response beat
rsp_shared_o  out  1  merged IsShared
rsp_dirty_o  out  1  PassDirty of data source
rsp_err_o  out  1  OR of all CR Error bits

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0; address/snoop/prot/data outputs 0; all masks cleared. Reset mid-transaction aborts immediately; no partial response completes.
- States: IDLE, SNOOP, SNOOP_DATA, MEM_REQ, MEM_DATA, RESP.
- IDLE: req_ready_o=1. On req_valid_i, latch addr/snoop/prot/src. Set ac_pend and cr_pend to all-ones with bit req_src_i cleared. Data class: req_snoop_i[3]==0 is read, else dataless. Next state SNOOP. If the target mask is empty (NoMstPorts==1): go to MEM_REQ for read class, RESP for dataless.
- SNOOP: ac_valid_o=ac_pend. Each bit clears on its own ac_valid&ac_ready. cr_ready_o=cr_pend&~ac_pend. On each CR handshake, clear the cr_pend bit, OR IsShared/Error into the merge registers, and set the dt_mask bit if DataTransfer. When both masks are empty: if dt_mask!=0, go to SNOOP_DATA; else if read class, go to MEM_REQ; else go to RESP.
- AC and CR registers are one cycle apart. AC is asserted the cycle after acceptance. Earliest response for an all-miss read is 3 cycles after acceptance plus memory latency.
- SNOOP_DATA: sel = lowest-index set bit of dt_mask, latched on entry. rsp_dirty_o = PassDirty of sel. The sel port forwards CD to rsp: rsp_valid_o=cd_valid_i[sel], cd_ready_o[sel]=rsp_ready_i, rsp_last_o=cd_last_i[sel]. Other dt_mask ports are drained with cd_ready_o=1 and their data is discarded. A port's dt_mask bit clears on its last beat. Exit to IDLE when dt_mask is empty.
- Dataless class with DataTransfer: drain all CD, then RESP (CleanUnique writeback is handled elsewhere).
- MEM_REQ: mem_ar_valid_o=1 until handshake, then MEM_DATA.
- MEM_DATA: mem_r forwarded to rsp with the same handshake coupling. rsp_dirty_o=0. Last handshake goes to IDLE.
- RESP: single beat, rsp_last_o=1, data 0. Held until rsp_ready_i, then IDLE.
- rsp_valid_o may only fall after a handshake. All shared outputs are stable while any valid is high.
- Simultaneous AC handshake on one port and CR on another in the same cycle: both are processed.

Decomposition:
- ccu_pkg: CRRESP bit-position localparams, snoop code constants (READ_ONCE 4'b0000, READ_SHARED 4'b0001, CLEAN_UNIQUE 4'b1001), state enum.
- Lowest-index select: reuse common_cells lzc. No further sub-module.

Test Plan:
- NoMstPorts=4, src=0, ReadShared, all CRRESP=0: AC on ports 1-3 only; mem_ar addr matches; 4 memory beats forwarded; rsp_shared=0, rsp_dirty=0.
- ReadShared, port2 CRRESP=5'b01101 (IsShared, PassDirty, DT): 4 CD beats from port2 forwarded; no mem_ar; rsp_shared=1, rsp_dirty=1.
- Ports 1 and 3 both DT: port1 data forwarded; port3 CD drained with cd_ready=1; return to IDLE only after both lasts.
- CleanUnique (1001), port1 ac_ready delayed 5 cycles: other ACs drop individually; single RESP beat with last=1 and data 0; port3 Error gives rsp_err=1.
- rsp_ready toggling 1/0 during CD: cd_ready[sel] mirrors rsp_ready; no beat lost or duplicated.
- rst_ni asserted in SNOOP_DATA: all valid/ready outputs 0 same cycle; next request handled cleanly.
